// File: rtl/aes128_encrypt_ctrl_pkg.sv
// Shared AES-128 definitions: FSM states, round count, Rcon table and GF(2^8) helpers.
package aes128_encrypt_ctrl_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } ctrl_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes128_encrypt_ctrl_if.sv
// Host-side handshake bundle: plaintext/key in, ciphertext out.
interface aes128_encrypt_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes128_encrypt_ctrl_key_step.sv
// One AES-128 key-expansion step: previous round key plus Rcon to next round key.
module aes128_key_step (
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);
  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  aes_sub_word u_sub (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_n0  = w_w0 ^ w_sub ^ {i_rcon, 24'h000000};
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign o_key = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes128_encrypt_ctrl_round.sv
// AES round primitives and the full (SubBytes/ShiftRows/MixColumns/AddRoundKey) round.
module aes_sbox
  import aes128_encrypt_ctrl_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  assign o_byte = sbox(i_byte);
endmodule

module aes_sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    aes_sbox u_sbox (
      .i_byte (i_word[8*b +: 8]),
      .o_byte (o_word[8*b +: 8])
    );
  end
endmodule

module aes_shift_rows (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  // Byte r+4c sits at [127-8(r+4c) -: 8]; row r rotates left by r columns.
  always_comb begin
    o_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o_state[127 - 8*(r + 4*c) -: 8] = i_state[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
  end
endmodule

module aes_mix_columns
  import aes128_encrypt_ctrl_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign o_state[127 - 32*c -: 32] = mix_col(i_state[127 - 32*c -: 32]);
  end
endmodule

module aes_add_round_key (
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_state
);
  assign o_state = i_state ^ i_round_key;
endmodule

module encrypt_round (
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_state
);
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  for (genvar c = 0; c < 4; c++) begin : g_sub
    aes_sub_word u_sub (
      .i_word (i_state[127 - 32*c -: 32]),
      .o_word (w_sb[127 - 32*c -: 32])
    );
  end

  aes_shift_rows u_sr (
    .i_state (w_sb),
    .o_state (w_sr)
  );

  aes_mix_columns u_mc (
    .i_state (w_sr),
    .o_state (w_mc)
  );

  aes_add_round_key u_ark (
    .i_state     (w_mc),
    .i_round_key (i_round_key),
    .o_state     (o_state)
  );
endmodule

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
module aes128_encrypt_ctrl
  import aes128_encrypt_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  aes128_encrypt_ctrl_if.slave       host,
  output logic                       busy,
  output logic [CNT_W-1:0]           round_idx
);
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NR - 1);

  ctrl_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [127:0]     r_state_reg, w_state_reg_nxt;
  logic [127:0]     r_key_reg, w_key_reg_nxt;

  logic [7:0]       w_rcon;
  logic [127:0]     w_rk;
  logic [127:0]     w_round_out;
  logic [127:0]     w_final_sb;
  logic [127:0]     w_final_sr;
  logic [127:0]     w_final_out;

  assign w_rcon = rcon(r_cnt[3:0]);

  aes128_key_step u_key_step (
    .i_key  (r_key_reg),
    .i_rcon (w_rcon),
    .o_key  (w_rk)
  );

  encrypt_round u_round (
    .i_state     (r_state_reg),
    .i_round_key (w_rk),
    .o_state     (w_round_out)
  );

  // Last round skips MixColumns, so it is built from the primitives directly.
  for (genvar c = 0; c < 4; c++) begin : g_final_sub
    aes_sub_word u_final_sub (
      .i_word (r_state_reg[127 - 32*c -: 32]),
      .o_word (w_final_sb[127 - 32*c -: 32])
    );
  end

  aes_shift_rows u_final_sr (
    .i_state (w_final_sb),
    .o_state (w_final_sr)
  );

  aes_add_round_key u_final_ark (
    .i_state     (w_final_sr),
    .i_round_key (w_rk),
    .o_state     (w_final_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_state_reg <= '0;
      r_key_reg   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_state_reg <= w_state_reg_nxt;
      r_key_reg   <= w_key_reg_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_state_reg_nxt = r_state_reg;
    w_key_reg_nxt   = r_key_reg;
    case (r_state)
      IDLE: begin
        if (host.in_valid) begin
          w_state_reg_nxt = host.in_data ^ host.in_key;
          w_key_reg_nxt   = host.in_key;
          w_cnt_nxt       = CNT_W'(1);
          w_state_nxt     = ROUND;
        end
      end
      ROUND: begin
        w_state_reg_nxt = w_round_out;
        w_key_reg_nxt   = w_rk;
        w_cnt_nxt       = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_ROUND) w_state_nxt = FINAL;
      end
      FINAL: begin
        w_state_reg_nxt = w_final_out;
        w_key_reg_nxt   = w_rk;
        w_cnt_nxt       = '0;
        w_state_nxt     = DONE;
      end
      DONE: begin
        if (host.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign host.in_ready  = (r_state == IDLE);
  assign host.out_valid = (r_state == DONE);
  assign host.out_data  = r_state_reg;
  assign busy           = (r_state == ROUND) || (r_state == FINAL);
  assign round_idx      = busy ? r_cnt : '0;
endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Self-checking bench for aes128_encrypt_ctrl against a byte-array AES-128 reference model.
module tb_aes128_encrypt_ctrl;
  localparam int unsigned CNT_W = 4;
  // Counting the accepting edge as clock 1, out_valid is high after clock 11: 10 edges later.
  localparam int unsigned LAT   = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] round_idx;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  sbox_t [256];

  aes128_encrypt_ctrl_if u_if ();

  aes128_encrypt_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .host      (u_if.slave),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box from the generator walk of GF(2^8)* (p steps by 3, q by 1/3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127 - 8*i -: 8];
      s[i] = pt[127 - 8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t[0] = sbox_t[k[13]] ^ rc;
      t[1] = sbox_t[k[14]];
      t[2] = sbox_t[k[15]];
      t[3] = sbox_t[k[12]];
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ t[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = s[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, wait for its result with out_ready=1, check value, latency and pulse width.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input bit noise, input bit chk_timing);
    int unsigned lat;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = pt;
    u_if.in_key    = key;
    u_if.out_ready = 1'b1;
    lat = 0;
    while (!u_if.in_ready && lat < 40) begin
      tick();
      lat++;
    end
    tick();
    u_if.in_valid = 1'b0;
    lat = 0;
    while (!u_if.out_valid && lat < 40) begin
      if (chk_timing) begin
        check({tag, "/round_idx"}, 128'(round_idx), 128'(lat + 1));
        check({tag, "/busy"}, 128'(busy), 128'(1));
      end
      if (noise) begin
        u_if.in_valid = 1'($urandom_range(1, 0));
        u_if.in_data  = rnd128();
        u_if.in_key   = rnd128();
      end
      tick();
      lat++;
    end
    u_if.in_valid = 1'b0;
    check({tag, "/latency"}, 128'(lat), 128'(LAT));
    check({tag, "/ct"}, u_if.out_data, exp);
    if (chk_timing) begin
      check({tag, "/done_busy"}, 128'(busy), 128'(0));
      check({tag, "/done_ridx"}, 128'(round_idx), 128'(0));
    end
    tick();
    check({tag, "/valid_drop"}, 128'(u_if.out_valid), 128'(0));
    check({tag, "/ready_back"}, 128'(u_if.in_ready), 128'(1));
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    logic [127:0] pt, key, exp, pt2, key2;
    logic [127:0] q_pt[$], q_key[$], q_exp[$];
    int unsigned  acc_edge[$];
    int unsigned  k, edge_n, n_in, n_out;
    bit           will_acc;

    build_sbox();
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_key    = '0;
    u_if.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", 128'(u_if.in_ready), 128'(1));
    check("rst/out_valid", 128'(u_if.out_valid), 128'(0));
    check("rst/out_data", u_if.out_data, '0);
    check("rst/busy", 128'(busy), 128'(0));
    check("rst/round_idx", 128'(round_idx), 128'(0));
    check("rst/key_reg", dut.r_key_reg, '0);
    check("rst/state_reg", dut.r_state_reg, '0);
    rst_n = 1'b1;
    tick();

    run_block("fips_b", PT_B, KEY_B, CT_B, 1'b0, 1'b1);
    run_block("fips_c", PT_C, KEY_C, CT_C, 1'b0, 1'b0);
    check("fips_c/key_reg", dut.r_key_reg, RK10C);

    for (int unsigned i = 0; i < 4; i++) begin
      pt  = rnd128();
      key = rnd128();
      run_block(i[0] ? "rand_noise" : "rand", pt, key, ref_encrypt(pt, key), i[0], 1'b0);
    end

    // Backpressure with in_valid noise, then release with a new block offered on the same cycle.
    pt  = rnd128();
    key = rnd128();
    exp = ref_encrypt(pt, key);
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = pt;
    u_if.in_key    = key;
    k = 0;
    while (!u_if.in_ready && k < 40) begin tick(); k++; end
    tick();
    u_if.in_valid = 1'b0;
    k = 0;
    while (!u_if.out_valid && k < 40) begin tick(); k++; end
    check("bp/ct", u_if.out_data, exp);
    for (int unsigned i = 0; i < 20; i++) begin
      u_if.in_valid = 1'($urandom_range(1, 0));
      u_if.in_data  = rnd128();
      u_if.in_key   = rnd128();
      tick();
      check("bp/hold_valid", 128'(u_if.out_valid), 128'(1));
      check("bp/hold_data", u_if.out_data, exp);
      check("bp/hold_ready", 128'(u_if.in_ready), 128'(0));
    end
    pt2  = rnd128();
    key2 = rnd128();
    u_if.in_valid  = 1'b1;
    u_if.in_data   = pt2;
    u_if.in_key    = key2;
    u_if.out_ready = 1'b1;
    tick();
    check("bp/release_valid", 128'(u_if.out_valid), 128'(0));
    check("bp/release_ready", 128'(u_if.in_ready), 128'(1));
    check("bp/no_capture", 128'(busy), 128'(0));
    tick();
    u_if.in_valid = 1'b0;
    check("bp/next_accept", 128'(busy), 128'(1));
    k = 0;
    while (!u_if.out_valid && k < 40) begin tick(); k++; end
    check("bp/next_ct", u_if.out_data, ref_encrypt(pt2, key2));
    tick();

    // Back-to-back: in_valid stays high with three blocks queued.
    for (int unsigned i = 0; i < 3; i++) begin
      q_pt.push_back(rnd128());
      q_key.push_back(rnd128());
      q_exp.push_back(ref_encrypt(q_pt[i], q_key[i]));
    end
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = q_pt[0];
    u_if.in_key    = q_key[0];
    edge_n = 0;
    n_in   = 0;
    n_out  = 0;
    for (int unsigned cyc = 0; cyc < 80 && n_out < 3; cyc++) begin
      will_acc = u_if.in_ready && u_if.in_valid;
      tick();
      edge_n++;
      if (will_acc) begin
        acc_edge.push_back(edge_n);
        n_in++;
        if (n_in < 3) begin
          u_if.in_data = q_pt[n_in];
          u_if.in_key  = q_key[n_in];
        end else begin
          u_if.in_valid = 1'b0;
        end
      end
      if (u_if.out_valid) begin
        check("b2b/ct", u_if.out_data, (n_out < 3) ? q_exp[n_out] : '0);
        n_out++;
      end
    end
    u_if.in_valid = 1'b0;
    check("b2b/n_out", 128'(n_out), 128'(3));
    check("b2b/n_accept", 128'(acc_edge.size()), 128'(3));
    for (int unsigned i = 1; i < acc_edge.size(); i++)
      check("b2b/accept_gap", 128'(acc_edge[i] - acc_edge[i-1]), 128'(12));
    tick();

    // Reset in the middle of round 5, then the App. B vector again.
    u_if.in_valid = 1'b1;
    u_if.in_data  = PT_B;
    u_if.in_key   = KEY_B;
    k = 0;
    while (!u_if.in_ready && k < 40) begin tick(); k++; end
    tick();
    u_if.in_valid = 1'b0;
    k = 0;
    while (round_idx != CNT_W'(5) && k < 20) begin tick(); k++; end
    check("rstmid/at_round5", 128'(round_idx), 128'(5));
    rst_n = 1'b0;
    #1;
    check("rstmid/out_valid", 128'(u_if.out_valid), 128'(0));
    check("rstmid/in_ready", 128'(u_if.in_ready), 128'(1));
    check("rstmid/busy", 128'(busy), 128'(0));
    check("rstmid/round_idx", 128'(round_idx), 128'(0));
    check("rstmid/out_data", u_if.out_data, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_block("rstmid/fips_b", PT_B, KEY_B, CT_B, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
